// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates one single-port RAM between an instruction and a data requester.
// Define MEM_PORT_ARB_RR_EN for round-robin on contention; the default gives the data port fixed priority.
module mem_port_arb #(
  parameter int MEM_WORD_BITS = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_req_i,
  input  logic [31:0]              i_addr_i,
  output logic                     i_gnt_o,
  output logic                     i_rvalid_o,
  output logic [31:0]              i_rdata_o,
  output logic                     i_err_o,
  input  logic                     d_req_i,
  input  logic                     d_we_i,
  input  logic [3:0]               d_be_i,
  input  logic [31:0]              d_addr_i,
  input  logic [31:0]              d_wdata_i,
  output logic                     d_gnt_o,
  output logic                     d_rvalid_o,
  output logic [31:0]              d_rdata_o,
  output logic                     d_err_o,
  output logic                     mem_en_o,
  output logic [3:0]               mem_we_o,
  output logic [MEM_WORD_BITS-1:0] mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  input  logic [31:0]              mem_rdata_i
);
  localparam int AW = MEM_WORD_BITS;
  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_e;
  state_e state_q, state_d;
  logic err_q, err_d, last_q, last_d;
  logic i_oor, d_oor, d_wins, gnt_i, gnt_d;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr_i[1:0], d_addr_i[1:0]};
  assign i_oor = |i_addr_i[31:AW+2];
  assign d_oor = |d_addr_i[31:AW+2];
`ifdef MEM_PORT_ARB_RR_EN
  assign d_wins = ~last_q;
`else
  assign d_wins = 1'b1;
`endif
  // Grants are gated by reset so nothing leaks out while rst_i is low.
  assign gnt_d = rst_i & d_req_i & (~i_req_i | d_wins);
  assign gnt_i = rst_i & i_req_i & ~gnt_d;
  assign i_gnt_o = gnt_i;
  assign d_gnt_o = gnt_d;
  assign mem_addr_o = gnt_d ? d_addr_i[AW+1:2] : i_addr_i[AW+1:2];
  assign mem_wdata_o = d_wdata_i;
  assign mem_en_o = gnt_d ? ~d_oor : gnt_i & ~i_oor;
  assign mem_we_o = (gnt_d & d_we_i & ~d_oor) ? d_be_i : 4'b0000;
  assign i_rvalid_o = rst_i & (state_q == RESP_I);
  assign d_rvalid_o = rst_i & (state_q == RESP_D);
  assign i_err_o = i_rvalid_o & err_q;
  assign d_err_o = d_rvalid_o & err_q;
  assign i_rdata_o = (i_rvalid_o & ~err_q) ? mem_rdata_i : 32'h0;
  assign d_rdata_o = (d_rvalid_o & ~err_q) ? mem_rdata_i : 32'h0;
  always_comb begin
    state_d = gnt_d ? RESP_D : gnt_i ? RESP_I : IDLE;
    err_d = gnt_d ? d_oor : gnt_i & i_oor;
    last_d = gnt_d ? 1'b1 : gnt_i ? 1'b0 : last_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      err_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed checks of mem_port_arb against a behavioural RAM.
// Expectations follow MEM_PORT_ARB_RR_EN when the bench is built with it defined.
module tb_mem_port_arb;
  logic clk = 1'b0;
  logic rst_i;
  logic i_req_i, i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_addr_i, i_rdata_o;
  logic d_req_i, d_we_i, d_gnt_o, d_rvalid_o, d_err_o;
  logic [3:0] d_be_i, mem_we_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o, mem_wdata_o, mem_rdata_i;
  logic mem_en_o;
  logic [11:0] mem_addr_o;
  logic [31:0] ram [4096];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_port_arb dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );
  always @(posedge clk) if (mem_en_o) begin
    for (int b = 0; b < 4; b++) if (mem_we_o[b]) ram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
    mem_rdata_i <= ram[mem_addr_o];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    i_req_i = 0; i_addr_i = 0;
    d_req_i = 0; d_we_i = 0; d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
  endtask
  logic [3:0] exp_d;
  initial begin
    for (int k = 0; k < 4096; k++) ram[k] = 32'h0;
    ram[4] = 32'hDEADBEEF;
    ram[8] = 32'hAABBCCDD;
    mem_rdata_i = 32'h0;
    idle_inputs();
    rst_i = 0;
    i_req_i = 1; i_addr_i = 32'h10;
    step(); step();
    chk("rst_i_gnt", {31'b0, i_gnt_o}, 0);
    chk("rst_mem_en", {31'b0, mem_en_o}, 0);
    chk("rst_rvalid", {30'b0, i_rvalid_o, d_rvalid_o}, 0);
    chk("rst_rdata", i_rdata_o | d_rdata_o, 0);
    i_req_i = 0;
    step();
    rst_i = 1;
    #1;
    chk("idle_mem_en", {31'b0, mem_en_o}, 0);
    i_req_i = 1; i_addr_i = 32'h0000_0010;
    #1;
    chk("i_gnt", {31'b0, i_gnt_o}, 1);
    chk("i_mem_en", {31'b0, mem_en_o}, 1);
    chk("i_mem_addr", {20'b0, mem_addr_o}, 4);
    step();
    idle_inputs();
    chk("i_rvalid", {31'b0, i_rvalid_o}, 1);
    chk("i_rdata", i_rdata_o, 32'hDEADBEEF);
    chk("i_err", {31'b0, i_err_o}, 0);
    chk("i_other_rvalid", {31'b0, d_rvalid_o}, 0);
    step();
    chk("i_rvalid_one_shot", {31'b0, i_rvalid_o}, 0);
    d_req_i = 1; d_we_i = 1; d_be_i = 4'b0011; d_addr_i = 32'h20; d_wdata_i = 32'h12345678;
    #1;
    chk("dw_gnt", {31'b0, d_gnt_o}, 1);
    chk("dw_we", {28'b0, mem_we_o}, 4'b0011);
    chk("dw_addr", {20'b0, mem_addr_o}, 8);
    step();
    d_we_i = 0; d_be_i = 4'b1111;
    #1;
    chk("dw_ack", {31'b0, d_rvalid_o}, 1);
    chk("dr_gnt_b2b", {31'b0, d_gnt_o}, 1);
    chk("dr_we", {28'b0, mem_we_o}, 0);
    step();
    idle_inputs();
    chk("dr_rvalid", {31'b0, d_rvalid_o}, 1);
    chk("dr_rdata", d_rdata_o, 32'hAABB5678);
    chk("dr_err", {31'b0, d_err_o}, 0);
    step();
    chk("d_idle", {31'b0, d_rvalid_o}, 0);
    rst_i = 0;
    step();
    rst_i = 1;
`ifdef MEM_PORT_ARB_RR_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    i_req_i = 1; i_addr_i = 32'h10;
    d_req_i = 1; d_addr_i = 32'h20;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("arb_d_gnt%0d", c), {31'b0, d_gnt_o}, {31'b0, exp_d[c]});
      chk($sformatf("arb_i_gnt%0d", c), {31'b0, i_gnt_o}, {31'b0, ~exp_d[c]});
      step();
      chk($sformatf("arb_rsp%0d", c), {30'b0, d_rvalid_o, i_rvalid_o}, exp_d[c] ? 2 : 1);
      chk($sformatf("arb_rdata%0d", c), exp_d[c] ? d_rdata_o : i_rdata_o,
          exp_d[c] ? 32'hAABB5678 : 32'hDEADBEEF);
    end
    idle_inputs();
    step();
    d_req_i = 1; d_addr_i = 32'h0001_0000;
    #1;
    chk("oor_gnt", {31'b0, d_gnt_o}, 1);
    chk("oor_mem_en", {31'b0, mem_en_o}, 0);
    step();
    idle_inputs();
    chk("oor_rvalid", {31'b0, d_rvalid_o}, 1);
    chk("oor_err", {31'b0, d_err_o}, 1);
    chk("oor_rdata", d_rdata_o, 0);
    step();
    chk("oor_err_clear", {31'b0, d_err_o}, 0);
    i_req_i = 1; i_addr_i = 32'h10;
    #1;
    chk("rst_drop_gnt", {31'b0, i_gnt_o}, 1);
    step();
    idle_inputs();
    rst_i = 0;
    #1;
    chk("rst_drop_rvalid", {31'b0, i_rvalid_o}, 0);
    chk("rst_drop_outs", {i_rdata_o[30:0] | d_rdata_o[30:0], mem_en_o}, 0);
    step();
    rst_i = 1;
    #1;
    chk("rst_drop_after", {30'b0, i_rvalid_o, d_rvalid_o}, 0);
    step();
    chk("rst_drop_idle", {30'b0, i_rvalid_o, d_rvalid_o}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
